// File: rtl/fp_conv_pkg.sv
// Shared definitions for the linear <-> compact floating-point converters.
// Holds default widths, the decoder FSM state type and the (S, E, F) triple type.
package fp_conv_pkg;

    localparam int FP_D_W = 12;
    localparam int FP_E_W = 3;
    localparam int FP_F_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } fp_dec_state_e;

    typedef struct packed {
        logic              sgn;
        logic [FP_E_W-1:0] exp;
        logic [FP_F_W-1:0] frac;
    } fp_triple_t;

endpackage

// File: rtl/fp_mag_shifter.sv
// Magnitude builder for floating_point_decoder: iterative one-bit-per-cycle shifter,
// or a single-cycle barrel shifter when FP_DEC_BARREL_EN is defined.
module fp_mag_shifter
    import fp_conv_pkg::*;
#(
    parameter int D_W = FP_D_W,
    parameter int E_W = FP_E_W,
    parameter int F_W = FP_F_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [E_W-1:0] e,
    input  logic [F_W-1:0] f,
    output logic [D_W-1:0] result,
    output logic           done
);

    logic [D_W-1:0] mag;
    logic [E_W-1:0] cnt;
    logic [D_W-1:0] f_ext;

    assign f_ext = {{(D_W-F_W){1'b0}}, f};

`ifdef FP_DEC_BARREL_EN
    logic [D_W-1:0] shifted;

    assign shifted = f_ext << e;
    // The whole shift happens on the load cycle, so the result is ready immediately.
    assign result  = load ? shifted : mag;
    assign done    = load;

    always_ff @(posedge clk) begin
        if (rst) begin
            mag <= '0;
            cnt <= '0;
        end else if (load) begin
            mag <= shifted;
            cnt <= '0;
        end else if (step && (cnt != '0)) begin
            mag <= mag << 1;
            cnt <= cnt - 1'b1;
        end
    end
`else
    assign result = mag;
    assign done   = step && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            mag <= '0;
            cnt <= '0;
        end else if (load) begin
            mag <= f_ext;
            cnt <= e;
        end else if (step && (cnt != '0)) begin
            mag <= mag << 1;
            cnt <= cnt - 1'b1;
        end
    end
`endif

endmodule

// File: rtl/floating_point_decoder.sv
// Converts a compact floating-point triple (S, E, F) into D = (-1)^S * F * 2^E.
// FP_DEC_BARREL_EN selects the single-cycle magnitude shifter in fp_mag_shifter.
module floating_point_decoder
    import fp_conv_pkg::*;
#(
    parameter int D_W = FP_D_W,
    parameter int E_W = FP_E_W,
    parameter int F_W = FP_F_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  S,
    input  logic [E_W-1:0]        E,
    input  logic [F_W-1:0]        F,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [D_W-1:0] D
);

    fp_dec_state_e  state_q, state_d;
    logic           sgn_q;
    logic           load, step, done;
    logic [D_W-1:0] result;

    function automatic logic signed [D_W-1:0] apply_sign(input logic [D_W-1:0] mag,
                                                         input logic           neg);
        logic signed [D_W-1:0] m;
        m = $signed(mag);
        return neg ? -m : m;
    endfunction

    // Kept outside the FSM process so the shifter's done path never loops back into it.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign load      = in_valid && in_ready;
    assign step      = (state_q == ST_SHIFT);

    fp_mag_shifter #(
        .D_W (D_W),
        .E_W (E_W),
        .F_W (F_W)
    ) u_shifter (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .e      (E),
        .f      (F),
        .result (result),
        .done   (done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (load) state_d = done ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (done) state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sgn_q   <= 1'b0;
            D       <= '0;
        end else begin
            state_q <= state_d;
            if (load) sgn_q <= S;
            // On the accepting cycle the sign has not been latched yet, so take it from the port.
            if (done) D <= apply_sign(result, load ? S : sgn_q);
        end
    end

endmodule
